// File: rtl/bsg_sync_sync_capture_ctrl.sv
// bsg_sync_sync_capture_ctrl
// Receive-side controller for a 2-phase request/ack crossing of a wide data bus.
// A request phase toggle (already synchronised into oclk) marks a new word on
// iclk_data_i. The block waits settle_cycles_p cycles so the bus can settle,
// captures it, and offers it with v/yumi. When the word is consumed, the block
// toggles the ack phase back to the sender.
//
// Ports
//   oclk_i               output-domain clock
//   oclk_reset_i         synchronous active-high reset
//   iclk_req_tog_sync_i  request phase, synchronised to oclk
//   iclk_data_i          sender data, held static while a request is pending
//   v_o / data_o         captured word and its valid flag
//   yumi_i               consumer takes the word (ignored while v_o=0)
//   oclk_ack_tog_o       ack phase back to the sender
//   err_o                sticky: request phase moved before it was acked
//
// state  | meaning
// IDLE   | no word held; waiting for req phase != ack phase
// SETTLE | request seen; counting settle cycles before capture
// VALID  | word captured and offered; waiting for yumi_i
module bsg_sync_sync_capture_ctrl #(
  parameter int width_p         = 128,
  parameter int settle_cycles_p = 2
) (
  input  logic               oclk_i,
  input  logic               oclk_reset_i,
  input  logic               iclk_req_tog_sync_i,
  input  logic [width_p-1:0] iclk_data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               oclk_ack_tog_o,
  output logic               err_o
);

  localparam int CNT_W = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((settle_cycles_p > 0) ? settle_cycles_p - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_VALID  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ph_q, req_ph_d;
  logic [width_p-1:0] data_q, data_d;
  logic               v_q, v_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               pending;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_ph_d = req_ph_q;
    data_d   = data_q;
    v_d      = v_q;
    ack_d    = ack_q;
    err_d    = err_q;

    pending = iclk_req_tog_sync_i ^ ack_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pending) begin
          req_ph_d = iclk_req_tog_sync_i;
          if (settle_cycles_p == 0) begin
            data_d  = iclk_data_i;
            v_d     = 1'b1;
            state_d = ST_VALID;
          end else begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          data_d  = iclk_data_i;
          v_d     = 1'b1;
          state_d = ST_VALID;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_VALID: begin
        if (yumi_i) begin
          ack_d   = ~ack_q;
          v_d     = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        v_d     = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Sender moved its request phase before we acked: flag it but keep going.
    if ((state_q == ST_SETTLE || state_q == ST_VALID) &&
        (iclk_req_tog_sync_i != req_ph_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge oclk_i) begin
    if (oclk_reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_ph_q <= 1'b0;
      data_q   <= '0;
      v_q      <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_ph_q <= req_ph_d;
      data_q   <= data_d;
      v_q      <= v_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign v_o            = v_q;
  assign data_o         = data_q;
  assign oclk_ack_tog_o = ack_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_bsg_sync_sync_capture_ctrl.sv
// Bench for bsg_sync_sync_capture_ctrl: a settle=0 instance driven from a vector
// table, and a settle=2 instance driven by hand sequences and random stimulus,
// checked every cycle against a transaction-level reference model.
module tb_bsg_sync_sync_capture_ctrl;

  localparam int W  = 128;
  localparam int S2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // settle = 0 instance
  logic         rst0, req0, yumi0, v0, ack0, err0;
  logic [W-1:0] data0, dout0;
  // settle = 2 instance
  logic         rst2, req2, yumi2, v2, ack2, err2;
  logic [W-1:0] data2, dout2;

  bsg_sync_sync_capture_ctrl #(.width_p(W), .settle_cycles_p(0)) dut0 (
    .oclk_i(clk), .oclk_reset_i(rst0), .iclk_req_tog_sync_i(req0),
    .iclk_data_i(data0), .v_o(v0), .data_o(dout0), .yumi_i(yumi0),
    .oclk_ack_tog_o(ack0), .err_o(err0));

  bsg_sync_sync_capture_ctrl #(.width_p(W), .settle_cycles_p(S2)) dut2 (
    .oclk_i(clk), .oclk_reset_i(rst2), .iclk_req_tog_sync_i(req2),
    .iclk_data_i(data2), .v_o(v2), .data_o(dout2), .yumi_i(yumi2),
    .oclk_ack_tog_o(ack2), .err_o(err2));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the settle=2 instance, in terms of transactions:
  // a word taken at cycle t becomes visible at t+1+S2, its data is the bus
  // value at cycle t+S2, and the ack flips the cycle after it is consumed.
  int           mcyc = 0;
  bit           m_busy = 0, m_ack = 0, m_err = 0, m_ph = 0;
  int           m_acq = 0, m_ready = 0;
  logic [W-1:0] m_data = '0;
  bit           check_en = 0;

  always @(posedge clk) begin
    if (rst2) begin
      m_busy = 0; m_ack = 0; m_err = 0; m_ph = 0; m_data = '0;
    end else begin
      if (m_busy && mcyc > m_acq && req2 != m_ph) m_err = 1;
      if (m_busy && mcyc >= m_ready && yumi2) begin
        m_ack  = !m_ack;
        m_busy = 0;
      end else if (!m_busy && (req2 != m_ack)) begin
        m_busy  = 1;
        m_ph    = req2;
        m_acq   = mcyc;
        m_ready = mcyc + 1 + S2;
      end
      if (m_busy && mcyc == m_ready - 1) m_data = data2;
    end
    mcyc++;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_v",    W'(v2),   W'(m_busy && mcyc >= m_ready));
      chk("model_ack",  W'(ack2), W'(m_ack));
      chk("model_err",  W'(err2), W'(m_err));
      chk("model_data", dout2,    m_data);
    end
  end

  task automatic wait_v(input int max, output int n);
    n = 0;
    while (!v2 && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!v2) begin
      failures++;
      $display("FAIL wait_v: v_o still 0 after %0d cycles, expected 1", n);
    end
  endtask

  typedef struct {
    logic         rst, req, yumi;
    logic [W-1:0] data;
    logic         ev, eack, eerr;
    logic [W-1:0] edata;
  } vec_t;

  vec_t vecs[13];
  localparam logic [W-1:0] DA = 128'hA5A5_0001;
  localparam logic [W-1:0] DB = 128'hB0B0_0002;
  localparam logic [W-1:0] DC = 128'hC3C3_0003;
  localparam logic [W-1:0] DBEEF = 128'hDEADBEEF_00112233_44556677_CAFEBEEF;

  int n;
  int stall [4] = '{0, 3, 0, 7};

  initial begin
    //        rst req yumi data    v ack err data_o
    vecs[0]  = '{1, 0, 0, '0,  0, 0, 0, '0};
    vecs[1]  = '{0, 0, 0, '0,  0, 0, 0, '0};
    vecs[2]  = '{0, 1, 0, DA,  1, 0, 0, DA};   // capture in one cycle
    vecs[3]  = '{0, 1, 1, DA,  0, 1, 0, DA};   // consume -> ack next cycle
    vecs[4]  = '{0, 1, 0, DB,  0, 1, 0, DA};   // stale phase: no re-entry
    vecs[5]  = '{0, 1, 1, DB,  0, 1, 0, DA};   // yumi with v=0 ignored
    vecs[6]  = '{0, 0, 0, DB,  1, 1, 0, DB};
    vecs[7]  = '{0, 0, 0, DB,  1, 1, 0, DB};   // consumer stall
    vecs[8]  = '{0, 1, 0, DB,  1, 1, 1, DB};   // req moved during VALID
    vecs[9]  = '{0, 1, 1, DB,  0, 0, 1, DB};
    vecs[10] = '{0, 1, 0, DC,  1, 0, 1, DC};   // err sticky, still runs
    vecs[11] = '{1, 1, 0, DC,  0, 0, 0, '0};
    vecs[12] = '{0, 0, 0, DC,  0, 0, 0, '0};

    rst2 = 1; req2 = 0; yumi2 = 0; data2 = '0;

    foreach (vecs[i]) begin
      rst0 = vecs[i].rst; req0 = vecs[i].req; yumi0 = vecs[i].yumi; data0 = vecs[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d_v", i),    W'(v0),   W'(vecs[i].ev));
      chk($sformatf("vec%0d_ack", i),  W'(ack0), W'(vecs[i].eack));
      chk($sformatf("vec%0d_err", i),  W'(err0), W'(vecs[i].eerr));
      chk($sformatf("vec%0d_data", i), dout0,    vecs[i].edata);
    end
    rst0 = 1; req0 = 0; yumi0 = 0; data0 = '0;

    // settle=2 instance: reset then idle
    @(negedge clk);
    check_en = 1;
    @(negedge clk);
    rst2 = 0;
    repeat (10) @(negedge clk);

    // latency: v at t+3, yumi at t+5, ack at t+6
    data2 = DBEEF; req2 = 1;
    wait_v(10, n);
    chk("latency_s2", W'(n), W'(3));
    chk("beef_data", dout2, DBEEF);
    @(negedge clk);
    @(negedge clk);
    yumi2 = 1;
    @(negedge clk);
    yumi2 = 0;
    chk("beef_v_after_yumi", W'(v2), W'(0));
    chk("beef_ack", W'(ack2), W'(1));

    // back-to-back words with consumer stalls 0/3/0/7
    rst2 = 1; req2 = 0;
    @(negedge clk);
    rst2 = 0;
    for (int w = 0; w < 4; w++) begin
      data2 = W'(w + 1); req2 = ~req2;
      wait_v(10, n);
      chk($sformatf("b2b_data%0d", w), dout2, W'(w + 1));
      repeat (stall[w]) @(negedge clk);
      yumi2 = 1;
      @(negedge clk);
      yumi2 = 0;
      repeat (2) @(negedge clk);
    end
    chk("b2b_ack_end", W'(ack2), W'(0));
    chk("b2b_err_end", W'(err2), W'(0));

    // protocol violation during SETTLE
    data2 = 128'h55; req2 = 1;
    @(negedge clk);
    req2 = 0;
    @(negedge clk);
    chk("viol_err", W'(err2), W'(1));
    wait_v(10, n);
    chk("viol_data", dout2, 128'h55);
    yumi2 = 1;
    @(negedge clk);
    yumi2 = 0;
    chk("viol_err_sticky", W'(err2), W'(1));

    // ack=1 with req=0 is pending again; reset while that word is VALID
    wait_v(10, n);
    req2 = 1; rst2 = 1;
    @(negedge clk);
    rst2 = 0;
    chk("rst_v", W'(v2), W'(0));
    chk("rst_ack", W'(ack2), W'(0));
    chk("rst_err", W'(err2), W'(0));
    yumi2 = 1;
    wait_v(10, n);
    chk("rst_relatency", W'(n), W'(3));
    chk("rst_no_ack_idle_yumi", W'(ack2), W'(0));
    @(negedge clk);
    yumi2 = 0;

    // random stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      rst2 = ($urandom_range(0, 299) == 0);
      if (!m_busy && req2 == m_ack && $urandom_range(0, 3) == 0) begin
        data2 = {$urandom, $urandom, $urandom, $urandom};
        req2  = ~req2;
      end else if (m_busy && $urandom_range(0, 149) == 0) begin
        req2 = ~req2;
      end
      yumi2 = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end

    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
